d_sram_like_bridge: RTL and testbench

D_SRAM_LIKE_BRIDGE -- requirements
Module: d_sram_like_bridge

---
 rtl/d_sram_like_bridge_pkg.sv | 15 +
 rtl/d_sram_like_bridge_size_dec.sv | 28 ++
 rtl/d_sram_like_bridge.sv | 100 ++++++++++
 tb/tb_d_sram_like_bridge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d_sram_like_bridge_pkg.sv
// Shared cpu package: data-bridge FSM state encodings and sram-like size codes.
package d_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } dbridgeState_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/d_sram_like_bridge_size_dec.sv
// Byte-enable to sram-like size decode. Sub-word sizes only with DBRIDGE_SUBWORD_EN;
// otherwise every access is a word access for a word-only slave.
module dbridge_size_dec
  import d_sram_like_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic       isWrite,
  output logic [1:0] size
);

  assign isWrite = |wen;

`ifdef DBRIDGE_SUBWORD_EN
  always_comb begin
    size = SIZE_WORD;
    if (isWrite) begin
      case (wen)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
        4'b0011, 4'b1100:                   size = SIZE_HALF;
        default:                            size = SIZE_WORD;
      endcase
    end
  end
`else
  assign size = SIZE_WORD;
`endif

endmodule

// File: rtl/d_sram_like_bridge.sv
// Core data-sram port to sram-like bus bridge, one outstanding access at a time.
// Optional DBRIDGE_SUBWORD_EN enables byte/half writes with unaligned addresses.
module d_sram_like_bridge
  import d_sram_like_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall,
  input  logic        longest_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  dbridgeState_t stateReg, stateNext;
  logic [31:0]   rdataBuf;
  logic          captureEn;
  logic          reqRaw;
  logic          stallRaw;
  logic          isWrite;
  logic [1:0]    decSize;
  logic [1:0]    addrLowMask;

  dbridge_size_dec uSizeDec (
    .wen     (data_sram_wen),
    .isWrite (isWrite),
    .size    (decSize)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= ST_IDLE;
      rdataBuf <= 32'd0;
    end else begin
      stateReg <= stateNext;
      if (captureEn) rdataBuf <= data_rdata;
    end
  end

  always_comb begin
    stateNext = stateReg;
    captureEn = 1'b0;
    reqRaw    = 1'b0;
    stallRaw  = 1'b0;
    case (stateReg)
      ST_IDLE, ST_ADDR: begin
        if (stateReg == ST_ADDR || data_sram_en) begin
          reqRaw   = 1'b1;
          stallRaw = 1'b1;
          // A combined addr_ok/data_ok skips DATA and completes immediately.
          if (data_addr_ok && data_data_ok) begin
            captureEn = 1'b1;
            stateNext = ST_HOLD;
          end else if (data_addr_ok) begin
            stateNext = ST_DATA;
          end else begin
            stateNext = ST_ADDR;
          end
        end
      end
      ST_DATA: begin
        stallRaw = ~data_data_ok;
        if (data_data_ok) begin
          captureEn = 1'b1;
          stateNext = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!longest_stall) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

`ifdef DBRIDGE_SUBWORD_EN
  assign addrLowMask = isWrite ? 2'b11 : 2'b00;
`else
  assign addrLowMask = 2'b00;
`endif

  assign data_req        = reqRaw & ~rst;
  assign d_stall         = stallRaw & ~rst;
  assign data_wr         = isWrite;
  assign data_size       = decSize;
  assign data_addr       = {data_sram_addr[31:2], data_sram_addr[1:0] & addrLowMask};
  assign data_wdata      = data_sram_wdata;
  // Forward the bus data in its acknowledge cycle so the core need not wait a cycle.
  assign data_sram_rdata = rst ? 32'd0 : (captureEn ? data_rdata : rdataBuf);

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Scoreboard bench for d_sram_like_bridge; expected sizes follow DBRIDGE_SUBWORD_EN.
module tb_d_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } reqExp_t;

  reqExp_t     reqQ[$];
  logic [31:0] rdQ[$];
  int          nAssert = 0;
  int          nFail   = 0;
  int          txnId   = 0;

  d_sram_like_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (txn %0d, t=%0t)", tag, got, exp, txnId, $time);
    end
  endtask

  function automatic logic [1:0] expSize(input logic [3:0] wen);
`ifdef DBRIDGE_SUBWORD_EN
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
      4'b0011, 4'b1100:                   return 2'd1;
      default:                            return 2'd2;
    endcase
`else
    return (wen == 4'b0000) ? 2'd2 : 2'd2;
`endif
  endfunction

  function automatic logic [31:0] expAddr(input logic [31:0] addr, input logic [3:0] wen);
`ifdef DBRIDGE_SUBWORD_EN
    return (wen != 4'b0000) ? addr : {addr[31:2], 2'b00};
`else
    return (wen == 4'b0000) ? {addr[31:2], 2'b00} : {addr[31:2], 2'b00};
`endif
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic popReq();
    reqExp_t e;
    if (reqQ.size() == 0) begin
      checkVal("sb_req_empty", 32'd0, 32'd1);
      return;
    end
    e = reqQ.pop_front();
    checkVal("req_addr", data_addr, e.addr);
    checkVal("req_size", {30'd0, data_size}, {30'd0, e.size});
    checkVal("req_wr", {31'd0, data_wr}, {31'd0, e.wr});
    checkVal("req_wdata", data_wdata, e.wdata);
  endtask

  task automatic popRdata();
    logic [31:0] e;
    if (rdQ.size() == 0) begin
      checkVal("sb_rd_empty", 32'd0, 32'd1);
      return;
    end
    e = rdQ.pop_front();
    checkVal("ack_rdata", data_sram_rdata, e);
  endtask

  // One complete core access: address wait states, optional combined ack, data waits, HOLD.
  task automatic runAccess(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                           input int addrWait, input bit combined, input int dataWait,
                           input logic [31:0] rd, input int holdCycles);
    txnId++;
    reqQ.push_back('{addr: expAddr(addr, wen), size: expSize(wen), wr: (wen != 4'b0000), wdata: wdata});
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    longest_stall   = 1'b1;
    data_addr_ok    = 1'b0;
    data_data_ok    = 1'b0;
    for (int i = 0; i < addrWait; i++) begin
      @(negedge clk);
      checkVal("req_wait", {31'd0, data_req}, 32'd1);
      checkVal("stall_wait", {31'd0, d_stall}, 32'd1);
      stepCycle();
    end
    data_addr_ok = 1'b1;
    if (combined) begin
      data_data_ok = 1'b1;
      data_rdata   = rd;
      rdQ.push_back(rd);
    end
    @(negedge clk);
    checkVal("req_accept", {31'd0, data_req}, 32'd1);
    checkVal("stall_accept", {31'd0, d_stall}, 32'd1);
    popReq();
    if (combined) popRdata();
    stepCycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!combined) begin
      for (int i = 0; i < dataWait; i++) begin
        @(negedge clk);
        checkVal("req_data_wait", {31'd0, data_req}, 32'd0);
        checkVal("stall_data_wait", {31'd0, d_stall}, 32'd1);
        stepCycle();
      end
      data_data_ok = 1'b1;
      data_rdata   = rd;
      rdQ.push_back(rd);
      @(negedge clk);
      checkVal("req_ack", {31'd0, data_req}, 32'd0);
      checkVal("stall_ack", {31'd0, d_stall}, 32'd0);
      popRdata();
      stepCycle();
      data_data_ok = 1'b0;
    end
    for (int i = 0; i < holdCycles; i++) begin
      data_rdata   = 32'hBAD0_0000 | i;
      data_data_ok = (i == 1);
      @(negedge clk);
      checkVal("hold_req", {31'd0, data_req}, 32'd0);
      checkVal("hold_stall", {31'd0, d_stall}, 32'd0);
      checkVal("hold_rdata", data_sram_rdata, rd);
      stepCycle();
    end
    data_data_ok  = 1'b0;
    longest_stall = 1'b0;
    @(negedge clk);
    checkVal("release_req", {31'd0, data_req}, 32'd0);
    checkVal("release_rdata", data_sram_rdata, rd);
    stepCycle();
    data_sram_en = 1'b0;
    @(negedge clk);
    checkVal("idle_stall", {31'd0, d_stall}, 32'd0);
    $display("txn %0d: addr=0x%08h wen=%b addrWait=%0d combined=%0d rdata=0x%08h hold=%0d",
             txnId, addr, wen, addrWait, combined, rd, holdCycles);
    stepCycle();
  endtask

  initial begin
    rst             = 1'b1;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h8000_0100;
    data_sram_wdata = 32'd0;
    longest_stall   = 1'b0;
    data_addr_ok    = 1'b1;
    data_data_ok    = 1'b1;
    data_rdata      = 32'hABCD_1234;
    @(negedge clk);
    checkVal("rst_req", {31'd0, data_req}, 32'd0);
    checkVal("rst_stall", {31'd0, d_stall}, 32'd0);
    checkVal("rst_rdata", data_sram_rdata, 32'd0);
    $display("txn %0d: reset state", txnId);
    data_sram_en = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    stepCycle();
    rst = 1'b0;
    stepCycle();

    runAccess(32'h8000_1234, 4'b0000, 32'h0,          0, 1'b0, 0, 32'hDEAD_BEEF, 0);
    runAccess(32'h8000_0003, 4'b0001, 32'h0000_00AB, 3, 1'b0, 1, 32'h0000_0000, 1);
    runAccess(32'h8000_0010, 4'b0000, 32'h0,          0, 1'b1, 0, 32'h0000_00FF, 2);
    runAccess(32'h8000_0020, 4'b0000, 32'h0,          1, 1'b0, 2, 32'h1234_5678, 5);
    runAccess(32'h8000_0042, 4'b1100, 32'hBEEF_0000, 1, 1'b0, 0, 32'h0000_0000, 0);
    runAccess(32'h8000_0017, 4'b0000, 32'h0,          2, 1'b1, 0, 32'hCAFE_F00D, 2);
    runAccess(32'h8000_0005, 4'b0110, 32'h00AA_BB00, 0, 1'b1, 0, 32'h5555_AAAA, 1);

    // Abandon an access in DATA with an asynchronous reset between clock edges.
    txnId++;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h8000_0200;
    longest_stall  = 1'b1;
    data_addr_ok   = 1'b1;
    stepCycle();
    data_addr_ok = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkVal("arst_req", {31'd0, data_req}, 32'd0);
    checkVal("arst_stall", {31'd0, d_stall}, 32'd0);
    checkVal("arst_rdata", data_sram_rdata, 32'd0);
    rst          = 1'b0;
    data_sram_en = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h1111_1111;
    @(negedge clk);
    checkVal("stray_rdata", data_sram_rdata, 32'd0);
    checkVal("stray_stall", {31'd0, d_stall}, 32'd0);
    checkVal("stray_req", {31'd0, data_req}, 32'd0);
    stepCycle();
    data_data_ok = 1'b0;
    @(negedge clk);
    checkVal("stray_buf", data_sram_rdata, 32'd0);
    $display("txn %0d: reset in DATA then stray data_ok", txnId);
    stepCycle();

    runAccess(32'h8000_0300, 4'b1111, 32'h0102_0304, 0, 1'b0, 0, 32'h7777_8888, 0);

    checkVal("sb_req_left", reqQ.size(), 32'd0);
    checkVal("sb_rd_left", rdQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
